dac_seq_ctrl: RTL and testbench

Multi-shot successor to the single-shot DAC playback controller. It sits between the waveform FIFO (AXI-Stream source) and one RFSoC DAC AXI-Stream input. On a trigger it plays back a pre-delay, then N shots of waveform data separated by programmable gaps, then a post-delay. Each shot applies independent head and tail masks. The controller detects FIFO underflow and supports abort. Configuration arrives as parallel, already-registered words from the channel config block.

---
 rtl/dac_seq_ctrl_pkg.sv | 16 +
 rtl/dac_seq_ctrl_out_mux.sv | 36 +++
 rtl/dac_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dac_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_seq_ctrl_pkg.sv
// Shared types and constants for the RFSoC DAC sequencing blocks.
package rfsoc_config;

  localparam int DAC_DATA_W = 256;
  localparam int CFG_CNT_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE      = 3'd1,
    ST_RUN      = 3'd2,
    ST_GAP      = 3'd3,
    ST_POST     = 3'd4,
    ST_WAIT_LOW = 3'd5
  } dac_seq_state_t;

endpackage

// File: rtl/dac_seq_ctrl_out_mux.sv
// Combinational DAC word select: locking wave, zeros, or FIFO data with
// optional head/tail AND-masks on the first/last beat of a shot.
module dac_out_mux
  import rfsoc_config::*;
#(
  parameter int DATA_W = DAC_DATA_W
) (
  input  dac_seq_state_t    state_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic              mask_en_i,
  input  logic [DATA_W-1:0] head_mask_i,
  input  logic [DATA_W-1:0] tail_mask_i,
  input  logic [DATA_W-1:0] locking_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] head_sel;
  logic [DATA_W-1:0] tail_sel;

  assign head_sel = (mask_en_i && first_i) ? head_mask_i : '1;
  assign tail_sel = (mask_en_i && last_i)  ? tail_mask_i : '1;

  // A starved RUN beat is forced to zero rather than replaying stale data.
  always_comb begin
    data_o = '0;
    case (state_i)
      ST_IDLE, ST_WAIT_LOW: data_o = locking_i;
      ST_RUN:               if (valid_i) data_o = data_i & head_sel & tail_sel;
      default:              data_o = '0;
    endcase
  end

endmodule

// File: rtl/dac_seq_ctrl.sv
// Multi-shot DAC playback sequencer: pre-delay, N masked shots separated by
// gaps, post-delay, then wait for the trigger to drop before re-arming.
module dac_seq_ctrl
  import rfsoc_config::*;
#(
  parameter int DATA_W = DAC_DATA_W,
  parameter int CNT_W  = CFG_CNT_W,
  parameter int REP_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              trigger_in,
  input  logic              abort_in,
  input  logic              clear_status,
  input  logic [CNT_W-1:0]  cfg_cycle_count,
  input  logic [CNT_W-1:0]  cfg_pre_delay,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [CNT_W-1:0]  cfg_post_delay,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic              cfg_mask_en,
  input  logic [DATA_W-1:0] cfg_head_mask,
  input  logic [DATA_W-1:0] cfg_tail_mask,
  input  logic [DATA_W-1:0] cfg_locking_wave,
  output logic              loopback_valid,
  output logic              busy,
  output logic              done_pulse,
  output logic              underflow,
  output dac_seq_state_t    state_dbg
);

  // Handshakes: the DAC side is always valid and m_axis_tready is ignored;
  // the FIFO side pops one word on every RUN cycle (s_axis_tready=1) whether
  // or not s_axis_tvalid is high, and a low tvalid there flags underflow.

  dac_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REP_W-1:0]  shot_q, shot_d;
  logic              done_q, done_d;
  logic              trig_q, uf_q;
  logic [CNT_W-1:0]  sh_count_q, sh_gap_q, sh_post_q;
  logic              sh_mask_en_q;
  logic [DATA_W-1:0] sh_head_q, sh_tail_q, sh_lock_q;

  logic              is_idle, trig_accept;
  logic [REP_W-1:0]  rep_m1, shot_cur;
  logic [CNT_W-1:0]  cur_count, cur_gap, cur_post;
  logic              shot_start, shot_end, finish;
  logic              unused_tready;

  assign unused_tready = m_axis_tready;
  assign is_idle     = (state_q == ST_IDLE);
  assign trig_accept = is_idle && trigger_in && !trig_q;
  assign rep_m1      = (cfg_repeat == '0) ? '0 : cfg_repeat - REP_W'(1);

  // In IDLE the decision for the trigger cycle is made from the live config,
  // because the shadow registers only load on that same edge.
  assign cur_count = is_idle ? cfg_cycle_count : sh_count_q;
  assign cur_gap   = is_idle ? cfg_gap         : sh_gap_q;
  assign cur_post  = is_idle ? cfg_post_delay  : sh_post_q;
  assign shot_cur  = is_idle ? rep_m1          : shot_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shot_d     = shot_q;
    done_d     = 1'b0;
    shot_start = 1'b0;
    shot_end   = 1'b0;
    finish     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_accept) begin
          shot_d = rep_m1;
          if (cfg_pre_delay != '0) begin
            state_d = ST_PRE;
            cnt_d   = cfg_pre_delay - CNT_W'(1);
          end else begin
            shot_start = 1'b1;
          end
        end
      end
      ST_PRE, ST_GAP: begin
        if (cnt_q == '0) shot_start = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      ST_RUN: begin
        if (cnt_q == '0) shot_end = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      ST_POST: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_LOW;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_LOW: if (!trigger_in) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // A zero-length shot ends the moment it starts.
    if (shot_start) begin
      if (cur_count != '0) begin
        state_d = ST_RUN;
        cnt_d   = cur_count - CNT_W'(1);
      end else begin
        shot_end = 1'b1;
      end
    end

    if (shot_end) begin
      if (shot_cur == '0) begin
        finish = 1'b1;
      end else begin
        shot_d = shot_cur - REP_W'(1);
        if (cur_gap != '0) begin
          state_d = ST_GAP;
          cnt_d   = cur_gap - CNT_W'(1);
        end else if (cur_count != '0) begin
          state_d = ST_RUN;
          cnt_d   = cur_count - CNT_W'(1);
        end else begin
          finish = 1'b1;
        end
      end
    end

    if (finish) begin
      if (cur_post != '0) begin
        state_d = ST_POST;
        cnt_d   = cur_post - CNT_W'(1);
      end else begin
        state_d = ST_WAIT_LOW;
        done_d  = 1'b1;
      end
    end

    if (abort_in && !is_idle) begin
      state_d = ST_WAIT_LOW;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shot_q       <= '0;
      done_q       <= 1'b0;
      trig_q       <= 1'b0;
      uf_q         <= 1'b0;
      sh_count_q   <= '0;
      sh_gap_q     <= '0;
      sh_post_q    <= '0;
      sh_mask_en_q <= 1'b0;
      sh_head_q    <= '0;
      sh_tail_q    <= '0;
      sh_lock_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shot_q  <= shot_d;
      done_q  <= done_d;
      trig_q  <= trigger_in;
      if (state_q == ST_RUN && !s_axis_tvalid) uf_q <= 1'b1;
      else if (clear_status)                   uf_q <= 1'b0;
      if (trig_accept) begin
        sh_count_q   <= cfg_cycle_count;
        sh_gap_q     <= cfg_gap;
        sh_post_q    <= cfg_post_delay;
        sh_mask_en_q <= cfg_mask_en;
        sh_head_q    <= cfg_head_mask;
        sh_tail_q    <= cfg_tail_mask;
        sh_lock_q    <= cfg_locking_wave;
      end
    end
  end

  dac_out_mux #(.DATA_W(DATA_W)) u_out_mux (
    .state_i     (state_q),
    .data_i      (s_axis_tdata),
    .valid_i     (s_axis_tvalid),
    .first_i     (cnt_q == sh_count_q - CNT_W'(1)),
    .last_i      (cnt_q == '0),
    .mask_en_i   (sh_mask_en_q),
    .head_mask_i (sh_head_q),
    .tail_mask_i (sh_tail_q),
    .locking_i   (is_idle ? cfg_locking_wave : sh_lock_q),
    .data_o      (m_axis_tdata)
  );

  assign m_axis_tvalid  = 1'b1;
  assign s_axis_tready  = (state_q == ST_RUN);
  assign loopback_valid = s_axis_tready;
  assign busy           = !is_idle;
  assign done_pulse     = done_q;
  assign underflow      = uf_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Bench for dac_seq_ctrl: per-cycle expected timeline built from the sequence
// rules, popped and compared by an independent monitor on the falling edge.
module tb_dac_seq_ctrl;
  import rfsoc_config::*;

  localparam int W = 256;
  localparam logic [1:0] K_LOCK = 2'd0, K_ZERO = 2'd1, K_BEAT = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic       ready;
    logic       busy;
    logic       done;
    logic       first;
    logic       last;
  } exp_t;

  logic           clk, rst;
  logic [W-1:0]   m_axis_tdata, s_axis_tdata;
  logic           m_axis_tvalid, m_axis_tready, s_axis_tvalid, s_axis_tready;
  logic           trigger_in, abort_in, clear_status;
  logic [31:0]    cfg_cycle_count, cfg_pre_delay, cfg_gap, cfg_post_delay;
  logic [15:0]    cfg_repeat;
  logic           cfg_mask_en;
  logic [W-1:0]   cfg_head_mask, cfg_tail_mask, cfg_locking_wave;
  logic           loopback_valid, busy, done_pulse, underflow;
  dac_seq_state_t state_dbg;

  exp_t         exp_q[$];
  logic         m_en, exp_uf;
  logic [W-1:0] m_head, m_tail, lock_wave;
  int           n_chk, n_pass;

  dac_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .trigger_in(trigger_in), .abort_in(abort_in), .clear_status(clear_status),
    .cfg_cycle_count(cfg_cycle_count), .cfg_pre_delay(cfg_pre_delay), .cfg_gap(cfg_gap),
    .cfg_post_delay(cfg_post_delay), .cfg_repeat(cfg_repeat), .cfg_mask_en(cfg_mask_en),
    .cfg_head_mask(cfg_head_mask), .cfg_tail_mask(cfg_tail_mask),
    .cfg_locking_wave(cfg_locking_wave), .loopback_valid(loopback_valid), .busy(busy),
    .done_pulse(done_pulse), .underflow(underflow), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic exp_t mk(input logic [1:0] kind, input logic ready, input logic bsy,
                              input logic dn, input logic first, input logic last);
    exp_t e;
    e.kind = kind; e.ready = ready; e.busy = bsy; e.done = dn; e.first = first; e.last = last;
    return e;
  endfunction

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s @%0t: got %b expected %b", name, $time, act, want);
  endtask

  // Monitor / scoreboard: one expected entry per clock while a sequence runs.
  always @(negedge clk) begin : monitor
    exp_t         e;
    logic [W-1:0] want, hm, tm;
    if (!rst) exp_uf = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(K_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hm = (m_en && e.first) ? m_head : '1;
    tm = (m_en && e.last)  ? m_tail : '1;
    case (e.kind)
      K_LOCK:  want = lock_wave;
      K_ZERO:  want = '0;
      default: want = s_axis_tvalid ? (s_axis_tdata & hm & tm) : '0;
    endcase
    chkw("m_axis_tdata", m_axis_tdata, want);
    chk1("s_axis_tready", s_axis_tready, e.ready);
    chk1("loopback_valid", loopback_valid, e.ready);
    chk1("busy", busy, e.busy);
    chk1("done_pulse", done_pulse, e.done);
    chk1("underflow", underflow, exp_uf);
    chk1("m_axis_tvalid", m_axis_tvalid, 1'b1);
    if (rst && e.kind == K_BEAT && !s_axis_tvalid) exp_uf = 1'b1;
    else if (rst && clear_status)                  exp_uf = 1'b0;
  end

  // FIFO data driver: fresh random word every cycle.
  initial begin
    s_axis_tdata = rand256();
    forever begin
      @(posedge clk); #1;
      s_axis_tdata = rand256();
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      abort_in = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    abort_in = 1'b0;
  endtask

  task automatic scramble_cfg();
    cfg_cycle_count = $urandom(); cfg_pre_delay = $urandom();
    cfg_gap = $urandom(); cfg_post_delay = $urandom();
    cfg_repeat = 16'($urandom()); cfg_mask_en = 1'($urandom());
    cfg_head_mask = rand256(); cfg_tail_mask = rand256();
  endtask

  // Drives one triggered sequence; offsets are in cycles from the trigger edge.
  task automatic run_seq(input int pre, input int cnt, input int rep, input int gap,
                         input int post, input int hold, input int abort_at,
                         input int drop_at, input int clr_at, input int rst_at,
                         input bit ab_trig, input bit scramble);
    int r, n, trig_low, c;
    r = (rep == 0) ? 1 : rep;
    cfg_pre_delay = 32'(pre); cfg_cycle_count = 32'(cnt); cfg_repeat = 16'(rep);
    cfg_gap = 32'(gap); cfg_post_delay = 32'(post);
    cfg_mask_en = m_en; cfg_head_mask = m_head; cfg_tail_mask = m_tail;
    exp_q.push_back(mk(K_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (pre) exp_q.push_back(mk(K_ZERO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int s = 0; s < r; s++) begin
      for (int b = 0; b < cnt; b++)
        exp_q.push_back(mk(K_BEAT, 1'b1, 1'b1, 1'b0, b == 0, b == cnt - 1));
      if (s < r - 1) repeat (gap) exp_q.push_back(mk(K_ZERO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    repeat (post) exp_q.push_back(mk(K_ZERO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(K_LOCK, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    repeat (hold) exp_q.push_back(mk(K_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    n = exp_q.size();
    trig_low = (abort_at >= 0) ? abort_at + hold + 1 : n - 1;
    c = 0;
    while (1) begin
      if (c == rst_at) begin
        rst = 1'b0; trigger_in = 1'b0; abort_in = 1'b0; clear_status = 1'b0;
        s_axis_tvalid = 1'b1;
        exp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        break;
      end
      trigger_in    = (c < trig_low);
      abort_in      = (c == abort_at) || (ab_trig && c == 0);
      s_axis_tvalid = (c != drop_at);
      clear_status  = (c == clr_at);
      if (c == abort_at) begin
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        repeat (hold + 1) exp_q.push_back(mk(K_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      if (scramble && c > 0) scramble_cfg();
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
      c++;
    end
    trigger_in = 1'b0; abort_in = 1'b0; clear_status = 1'b0; s_axis_tvalid = 1'b1;
  endtask

  // Main stimulus
  initial begin
    n_chk = 0; n_pass = 0; exp_uf = 1'b0;
    rst = 1'b0; m_axis_tready = 1'b1; s_axis_tvalid = 1'b1;
    trigger_in = 1'b0; abort_in = 1'b0; clear_status = 1'b0;
    lock_wave = rand256(); cfg_locking_wave = lock_wave;
    m_en = 1'b0; m_head = '1; m_tail = '1;
    run_seq_defaults();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    idle(10);

    // Single shot with 0x00FF masks on head and tail beats.
    m_en = 1'b1; m_head = {16{16'h00FF}}; m_tail = {16{16'h00FF}};
    run_seq(2, 4, 1, 0, 3, 0, -1, -1, -1, -1, 1'b0, 1'b1);
    idle(3);
    // Three bursts of three beats with two-cycle gaps.
    m_head = rand256(); m_tail = rand256();
    run_seq(0, 3, 3, 2, 1, 0, -1, -1, -1, -1, 1'b0, 1'b1);
    idle(3);
    // Single-beat shots back to back: both masks on each beat.
    m_head = rand256(); m_tail = rand256();
    run_seq(1, 1, 2, 0, 0, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    idle(3);
    // Underflow: set on beat 2, sticky, cleared, then set-and-clear together.
    m_en = 1'b0;
    run_seq(1, 4, 1, 0, 1, 0, -1, 3, -1, -1, 1'b0, 1'b0);
    idle(4);
    run_seq(1, 4, 1, 0, 1, 0, -1, -1, 2, -1, 1'b0, 1'b0);
    idle(2);
    run_seq(1, 4, 1, 0, 1, 0, -1, 3, 3, -1, 1'b0, 1'b0);
    idle(3);
    // Abort after beat 2 of 8 with trigger held, then a clean retrigger.
    run_seq(0, 8, 1, 0, 2, 3, 2, -1, -1, -1, 1'b0, 1'b0);
    idle(3);
    run_seq(0, 2, 1, 0, 1, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    idle(3);
    // Trigger edge and abort together in IDLE: trigger wins.
    run_seq(1, 2, 1, 0, 1, 0, -1, -1, -1, -1, 1'b1, 1'b0);
    idle(3);
    // Trigger held past completion: no retrigger.
    run_seq(0, 2, 2, 1, 1, 3, -1, -1, -1, -1, 1'b0, 1'b0);
    idle(3);
    // Reset asserted mid-gap, then a full sequence.
    run_seq(0, 3, 3, 5, 2, 0, -1, 3, -1, 5, 1'b0, 1'b0);
    idle(3);
    run_seq(0, 3, 3, 5, 2, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    idle(3);
    // Zero-length shots and repeat corner cases.
    run_seq(0, 0, 3, 2, 1, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    idle(2);
    run_seq(0, 0, 0, 0, 0, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    idle(2);
    run_seq(2, 0, 65535, 0, 0, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    idle(2);
    run_seq(0, 2, 0, 0, 0, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    idle(2);

    // Randomized sequences with mid-sequence config scrambling.
    for (int k = 0; k < 40; k++) begin
      int pre, cnt, rep, gap, post, hold, r, core, ab, dr, cl;
      pre = $urandom_range(0, 3); cnt = $urandom_range(0, 5); rep = $urandom_range(0, 3);
      gap = $urandom_range(0, 2); post = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      m_en = 1'($urandom()); m_head = rand256(); m_tail = rand256();
      r = (rep == 0) ? 1 : rep;
      core = pre + r * cnt + (r - 1) * gap + post;
      ab = (core > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, core) : -1;
      dr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : -1;
      cl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : -1;
      run_seq(pre, cnt, rep, gap, post, hold, ab, dr, cl, -1, 1'b0, 1'b1);
      idle($urandom_range(1, 4));
    end

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  task automatic run_seq_defaults();
    cfg_pre_delay = '0; cfg_cycle_count = '0; cfg_repeat = '0; cfg_gap = '0;
    cfg_post_delay = '0; cfg_mask_en = 1'b0; cfg_head_mask = '0; cfg_tail_mask = '0;
  endtask

endmodule
